// File: rtl/data_cache_pkg.sv
// Shared types, default geometry and address-field helpers for the data cache.
// DATA_CACHE_STATS_EN in data_cache.sv enables the optional hit/miss counters.
package data_cache_pkg;

    localparam int ADDRESS_WIDTH = 32;
    localparam int DATA_WIDTH    = 32;
    localparam int SETS          = 8;
    localparam int INDEX_BITS    = $clog2(SETS);
    localparam int TAG_BITS      = ADDRESS_WIDTH - 2 - INDEX_BITS;

    localparam int MAX_AW = 64;
    typedef logic [MAX_AW-1:0] addr_wide_t;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        WRITE,
        RESP
    } state_t;

    // Helpers work on a widened address so any cache geometry can reuse them;
    // callers size-cast the result back to their own field width.
    function automatic addr_wide_t addr_index(input addr_wide_t addr, input int unsigned ib);
        return (addr >> 2) & ((addr_wide_t'(1) << ib) - addr_wide_t'(1));
    endfunction

    function automatic addr_wide_t addr_tag(input addr_wide_t addr, input int unsigned ib);
        return addr >> (ib + 2);
    endfunction

    function automatic addr_wide_t word_addr(input addr_wide_t addr);
        return addr & ~addr_wide_t'(3);
    endfunction

endpackage

// File: rtl/data_cache_if.sv
// Core load/store port and backing-memory port of the data cache in one bundle.
// The slave modport is the cache's view; master is the core/memory environment.
interface data_cache_if #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32
);

    logic                     cpu_re;
    logic                     cpu_we;
    logic [ADDRESS_WIDTH-1:0] cpu_addr;
    logic [DATA_WIDTH-1:0]    cpu_wd;
    logic [DATA_WIDTH-1:0]    cpu_rd;
    logic                     cpu_stall;

    logic                     mem_req;
    logic                     mem_we;
    logic [ADDRESS_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0]    mem_wd;
    logic [DATA_WIDTH-1:0]    mem_rd;
    logic                     mem_ack;

    modport slave (
        input  cpu_re, cpu_we, cpu_addr, cpu_wd,
        output cpu_rd, cpu_stall,
        output mem_req, mem_we, mem_addr, mem_wd,
        input  mem_rd, mem_ack
    );

    modport master (
        output cpu_re, cpu_we, cpu_addr, cpu_wd,
        input  cpu_rd, cpu_stall,
        input  mem_req, mem_we, mem_addr, mem_wd,
        output mem_rd, mem_ack
    );

endinterface

// File: rtl/data_cache_store.sv
// Valid/tag/data arrays of the direct-mapped cache: combinational lookup,
// one synchronous write port, valid bits cleared by rst.
module data_cache_store #(
    parameter int DATA_WIDTH = 32,
    parameter int SETS       = 8,
    parameter int TAG_BITS   = 27
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [$clog2(SETS)-1:0] lookup_index,
    input  logic [TAG_BITS-1:0]     lookup_tag,
    output logic                    hit,
    output logic [DATA_WIDTH-1:0]   rd_data,
    input  logic                    wr_en,
    input  logic                    wr_set_valid,
    input  logic [$clog2(SETS)-1:0] wr_index,
    input  logic [TAG_BITS-1:0]     wr_tag,
    input  logic [DATA_WIDTH-1:0]   wr_data
);

    logic [SETS-1:0]       valid;
    logic [TAG_BITS-1:0]   tags  [SETS];
    logic [DATA_WIDTH-1:0] lines [SETS];

    assign hit     = valid[lookup_index] && (tags[lookup_index] == lookup_tag);
    assign rd_data = lines[lookup_index];

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= '0;
        end else if (wr_en && wr_set_valid) begin
            valid[wr_index] <= 1'b1;
        end
    end

    // Tag only changes on allocation; a store hit just refreshes the data word.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            lines[wr_index] <= wr_data;
            if (wr_set_valid) begin
                tags[wr_index] <= wr_tag;
            end
        end
    end

endmodule

// File: rtl/data_cache.sv
// Direct-mapped, write-through, no-write-allocate data cache (one word per line).
// Define DATA_CACHE_STATS_EN to add the hit_count/miss_count outputs.
module data_cache
    import data_cache_pkg::*;
#(
    parameter int ADDRESS_WIDTH = data_cache_pkg::ADDRESS_WIDTH,
    parameter int DATA_WIDTH    = data_cache_pkg::DATA_WIDTH,
    parameter int SETS          = data_cache_pkg::SETS
) (
    input  logic        clk,
    input  logic        rst,
    data_cache_if.slave bus
`ifdef DATA_CACHE_STATS_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
`endif
);

    localparam int IB = $clog2(SETS);
    localparam int TB = ADDRESS_WIDTH - 2 - IB;

    state_t                   state;
    logic                     mem_req_q;
    logic                     mem_we_q;
    logic [ADDRESS_WIDTH-1:0] mem_addr_q;
    logic [DATA_WIDTH-1:0]    mem_wd_q;
    logic [DATA_WIDTH-1:0]    resp_data;

    logic [ADDRESS_WIDTH-1:0] lookup_addr;
    logic [ADDRESS_WIDTH-1:0] cpu_word_addr;
    logic [IB-1:0]            lookup_index;
    logic [TB-1:0]            lookup_tag;
    logic                     hit;
    logic [DATA_WIDTH-1:0]    line_data;
    logic                     wr_en;
    logic                     wr_set_valid;
    logic [DATA_WIDTH-1:0]    wr_data;
    logic                     stall;
    logic [DATA_WIDTH-1:0]    rd;

    // The latched memory address doubles as the request latch for FILL/WRITE lookups.
    assign lookup_addr   = (state == IDLE) ? bus.cpu_addr : mem_addr_q;
    assign cpu_word_addr = ADDRESS_WIDTH'(word_addr(addr_wide_t'(bus.cpu_addr)));
    assign lookup_index  = IB'(addr_index(addr_wide_t'(lookup_addr), IB));
    assign lookup_tag    = TB'(addr_tag(addr_wide_t'(lookup_addr), IB));

    data_cache_store #(
        .DATA_WIDTH (DATA_WIDTH),
        .SETS       (SETS),
        .TAG_BITS   (TB)
    ) u_store (
        .clk          (clk),
        .rst          (rst),
        .lookup_index (lookup_index),
        .lookup_tag   (lookup_tag),
        .hit          (hit),
        .rd_data      (line_data),
        .wr_en        (wr_en),
        .wr_set_valid (wr_set_valid),
        .wr_index     (lookup_index),
        .wr_tag       (lookup_tag),
        .wr_data      (wr_data)
    );

    always_comb begin
        wr_en        = 1'b0;
        wr_set_valid = 1'b0;
        wr_data      = bus.mem_rd;
        if (!rst && bus.mem_ack) begin
            if (state == FILL) begin
                wr_en        = 1'b1;
                wr_set_valid = 1'b1;
            end else if (state == WRITE) begin
                wr_en   = hit;
                wr_data = mem_wd_q;
            end
        end
    end

    // Stall is combinational in IDLE so a miss or store freezes the core in the request cycle.
    always_comb begin
        stall = 1'b0;
        rd    = '0;
        if (!rst) begin
            case (state)
                IDLE: begin
                    if (bus.cpu_we) begin
                        stall = 1'b1;
                    end else if (bus.cpu_re) begin
                        if (hit) begin
                            rd = line_data;
                        end else begin
                            stall = 1'b1;
                        end
                    end
                end
                FILL, WRITE: stall = 1'b1;
                RESP:        rd    = resp_data;
                default: ;
            endcase
        end
    end

    assign bus.cpu_stall = stall;
    assign bus.cpu_rd    = rd;
    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wd    = mem_wd_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            mem_req_q  <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_wd_q   <= '0;
            resp_data  <= '0;
`ifdef DATA_CACHE_STATS_EN
            hit_count  <= '0;
            miss_count <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.cpu_we) begin
                        state      <= WRITE;
                        mem_req_q  <= 1'b1;
                        mem_we_q   <= 1'b1;
                        mem_addr_q <= cpu_word_addr;
                        mem_wd_q   <= bus.cpu_wd;
                    end else if (bus.cpu_re && !hit) begin
                        state      <= FILL;
                        mem_req_q  <= 1'b1;
                        mem_we_q   <= 1'b0;
                        mem_addr_q <= cpu_word_addr;
                        mem_wd_q   <= '0;
`ifdef DATA_CACHE_STATS_EN
                        miss_count <= miss_count + 32'd1;
`endif
                    end else if (bus.cpu_re) begin
`ifdef DATA_CACHE_STATS_EN
                        hit_count  <= hit_count + 32'd1;
`endif
                    end
                end
                FILL, WRITE: begin
                    if (bus.mem_ack) begin
                        state      <= RESP;
                        resp_data  <= (state == FILL) ? bus.mem_rd : '0;
                        mem_req_q  <= 1'b0;
                        mem_we_q   <= 1'b0;
                        mem_addr_q <= '0;
                        mem_wd_q   <= '0;
                    end
                end
                RESP: begin
                    state     <= IDLE;
                    resp_data <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_cache.sv
// Scoreboard bench for data_cache: randomized loads/stores against a word-level
// memory model plus a line-ownership model; a monitor checks every retired access.
module tb_data_cache;

    localparam int NSETS = 8;

    typedef struct {
        string       name;
        logic [31:0] rd;
        int          stalls;
    } exp_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wd;
    } mem_exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic resp_ack = 1'b0;
    logic late_ack = 1'b0;

    int checks = 0;
    int fails  = 0;
    int latency = 1;

    exp_t        exp_q[$];
    mem_exp_t    mem_q[$];
    logic [31:0] ref_mem [logic [31:0]];
    logic [31:0] backing [logic [31:0]];
    bit          line_valid [NSETS];
    logic [31:0] line_addr  [NSETS];
    int          exp_hits   = 0;
    int          exp_misses = 0;

    data_cache_if #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32)) bus();

`ifdef DATA_CACHE_STATS_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    data_cache dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus)
`ifdef DATA_CACHE_STATS_EN
        ,
        .hit_count  (hit_count),
        .miss_count (miss_count)
`endif
    );

    assign bus.mem_ack = resp_ack | late_ack;

    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return {a[15:0] ^ 16'hC3A5, a[15:0]};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic finish_test();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    endtask

    task automatic clear_model();
        for (int i = 0; i < NSETS; i++) begin
            line_valid[i] = 1'b0;
            line_addr[i]  = '0;
        end
        exp_hits   = 0;
        exp_misses = 0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One core access: predict the outcome, push expectations, hold until retired.
    task automatic applyStimulus(input bit re, input bit we, input logic [31:0] addr,
                                 input logic [31:0] wd, input int lat, input string name);
        exp_t        e;
        mem_exp_t    m;
        int          idx;
        logic [31:0] waddr;
        bit          hit;
        bit          done;
        idx   = int'((addr >> 2) % NSETS);
        waddr = addr & ~32'd3;
        hit   = line_valid[idx] && (line_addr[idx] == waddr);
        e.name = name;
        if (we) begin
            e.rd     = '0;
            e.stalls = 1 + lat;
            m.we = 1'b1; m.addr = waddr; m.wd = wd;
            mem_q.push_back(m);
            ref_mem[waddr] = wd;
        end else begin
            e.rd = ref_mem.exists(waddr) ? ref_mem[waddr] : init_word(waddr);
            if (hit) begin
                e.stalls = 0;
                exp_hits++;
            end else begin
                e.stalls = 1 + lat;
                m.we = 1'b0; m.addr = waddr; m.wd = '0;
                mem_q.push_back(m);
                line_valid[idx] = 1'b1;
                line_addr[idx]  = waddr;
                exp_misses++;
            end
        end
        exp_q.push_back(e);
        latency      = lat;
        bus.cpu_re   = re;
        bus.cpu_we   = we;
        bus.cpu_addr = addr;
        bus.cpu_wd   = wd;
        done = 1'b0;
        for (int c = 0; c < 100 && !done; c++) begin
            @(negedge clk);
            if (!bus.cpu_stall) done = 1'b1;
        end
        if (!done) begin
            checks++;
            fails++;
            $display("[TB] FAIL %s_timeout: stall still 1 after 100 cycles, required retire", name);
            finish_test();
        end
        @(posedge clk);
        #1;
        bus.cpu_re   = 1'b0;
        bus.cpu_we   = 1'b0;
        bus.cpu_addr = $urandom();
        bus.cpu_wd   = $urandom();
    endtask

    task automatic do_reset(input bit probe);
        rst          = 1'b1;
        bus.cpu_re   = probe;
        bus.cpu_we   = 1'b0;
        bus.cpu_addr = 32'h100;
        bus.cpu_wd   = '0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("rst_cpu_stall", {31'd0, bus.cpu_stall}, 32'd0);
        checkOutput("rst_cpu_rd", bus.cpu_rd, 32'd0);
        checkOutput("rst_mem_req", {31'd0, bus.mem_req}, 32'd0);
        checkOutput("rst_mem_we", {31'd0, bus.mem_we}, 32'd0);
        checkOutput("rst_mem_addr", bus.mem_addr, 32'd0);
        checkOutput("rst_mem_wd", bus.mem_wd, 32'd0);
        @(posedge clk);
        #1;
        rst        = 1'b0;
        bus.cpu_re = 1'b0;
        mem_q.delete();
        clear_model();
    endtask

    // Monitor: count stall cycles of the pending access and check it when it retires.
    initial begin : monitor
        int   stall_cnt;
        exp_t e;
        stall_cnt = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                stall_cnt = 0;
            end else if (bus.cpu_re || bus.cpu_we) begin
                if (bus.cpu_stall) begin
                    stall_cnt++;
                end else begin
                    if (exp_q.size() == 0) begin
                        checkOutput("unexpected_retire", 32'd1, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        checkOutput({e.name, "_rd"}, bus.cpu_rd, e.rd);
                        checkOutput({e.name, "_stalls"}, 32'(stall_cnt), 32'(e.stalls));
                    end
                    stall_cnt = 0;
                end
            end
        end
    end

    // Backing memory: checks the held request each cycle and acks after `latency` cycles.
    initial begin : responder
        int       cnt;
        mem_exp_t m;
        cnt = 0;
        bus.mem_rd = '0;
        forever begin
            @(posedge clk);
            #1;
            resp_ack   = 1'b0;
            bus.mem_rd = $urandom();
            if (bus.mem_req === 1'b1 && !rst) begin
                if (mem_q.size() == 0) begin
                    checkOutput("unexpected_mem_req", {31'd0, bus.mem_req}, 32'd0);
                end else begin
                    m = mem_q[0];
                    checkOutput("mem_we", {31'd0, bus.mem_we}, {31'd0, m.we});
                    checkOutput("mem_addr", bus.mem_addr, m.addr);
                    checkOutput("mem_wd", bus.mem_wd, m.wd);
                    cnt++;
                    if (cnt >= latency) begin
                        resp_ack = 1'b1;
                        if (m.we) begin
                            backing[m.addr] = m.wd;
                        end else begin
                            bus.mem_rd = backing.exists(m.addr) ? backing[m.addr] : init_word(m.addr);
                        end
                        void'(mem_q.pop_front());
                        cnt = 0;
                    end
                end
            end else begin
                cnt = 0;
            end
        end
    end

    initial begin : stimulus
        logic [31:0] addr;
        int          kind;
        bus.cpu_re   = 1'b0;
        bus.cpu_we   = 1'b0;
        bus.cpu_addr = '0;
        bus.cpu_wd   = '0;
        ref_mem[32'h100] = 32'hDEADBEEF;
        backing[32'h100] = 32'hDEADBEEF;
        clear_model();

        do_reset(1'b1);

        $display("[TB] Load miss, hit, store hit, eviction, no-allocate store");
        applyStimulus(1, 0, 32'h100, 32'h0, 3, "load_miss_100");
        applyStimulus(1, 0, 32'h100, 32'h0, 3, "load_hit_100");
        applyStimulus(0, 1, 32'h100, 32'h12345678, 2, "store_hit_100");
        applyStimulus(1, 0, 32'h102, 32'h0, 2, "load_after_store");
        applyStimulus(1, 0, 32'h120, 32'h0, 1, "load_miss_120");
        applyStimulus(1, 0, 32'h100, 32'h0, 1, "reload_evicted_100");
        applyStimulus(0, 1, 32'h200, 32'hA5A5A5A5, 1, "store_miss_200");
        applyStimulus(1, 0, 32'h200, 32'h0, 2, "load_miss_200");
        applyStimulus(1, 1, 32'h200, 32'h0BADF00D, 1, "re_we_store");

        $display("[TB] Reset in the middle of a fill");
        latency = 1000;
        mem_q.push_back('{we: 1'b0, addr: 32'h100, wd: 32'h0});
        exp_q.push_back('{name: "aborted", rd: 32'h0, stalls: 0});
        bus.cpu_re   = 1'b1;
        bus.cpu_addr = 32'h100;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst        = 1'b0;
        bus.cpu_re = 1'b0;
        late_ack   = 1'b1;
        mem_q.delete();
        exp_q.delete();
        clear_model();
        @(negedge clk);
        checkOutput("abort_mem_req", {31'd0, bus.mem_req}, 32'd0);
        checkOutput("abort_cpu_stall", {31'd0, bus.cpu_stall}, 32'd0);
        @(posedge clk);
        #1;
        late_ack = 1'b0;
        @(negedge clk);
        checkOutput("late_ack_mem_req", {31'd0, bus.mem_req}, 32'd0);
        checkOutput("late_ack_cpu_rd", bus.cpu_rd, 32'd0);
        @(posedge clk);
        #1;
        applyStimulus(1, 0, 32'h100, 32'h0, 2, "load_after_abort");

        $display("[TB] Counter sequence");
        do_reset(1'b0);
        applyStimulus(1, 0, 32'h300, 32'h0, 1, "cnt_miss_a");
        applyStimulus(1, 0, 32'h304, 32'h0, 2, "cnt_miss_b");
        applyStimulus(1, 0, 32'h300, 32'h0, 1, "cnt_hit_a");
        applyStimulus(1, 0, 32'h304, 32'h0, 1, "cnt_hit_b");
        applyStimulus(1, 0, 32'h301, 32'h0, 1, "cnt_hit_c");
        applyStimulus(0, 1, 32'h308, 32'h77, 1, "cnt_store");
`ifdef DATA_CACHE_STATS_EN
        checkOutput("hit_count_seq", hit_count, 32'(exp_hits));
        checkOutput("miss_count_seq", miss_count, 32'(exp_misses));
`endif

        $display("[TB] Randomized accesses");
        for (int n = 0; n < 150; n++) begin
            addr = 32'h100 + ($urandom_range(0, 3) << 5) + ($urandom_range(0, 7) << 2) + $urandom_range(0, 3);
            kind = $urandom_range(0, 9);
            if (kind <= 5) begin
                applyStimulus(1, 0, addr, $urandom(), $urandom_range(1, 4), "rand_load");
            end else if (kind <= 8) begin
                applyStimulus(0, 1, addr, $urandom(), $urandom_range(1, 4), "rand_store");
            end else begin
                applyStimulus(1, 1, addr, $urandom(), $urandom_range(1, 4), "rand_re_we");
            end
            idle_cycles($urandom_range(0, 2));
        end

        idle_cycles(3);
        checkOutput("exp_q_drained", 32'(exp_q.size()), 32'd0);
        checkOutput("mem_q_drained", 32'(mem_q.size()), 32'd0);
`ifdef DATA_CACHE_STATS_EN
        checkOutput("hit_count_final", hit_count, 32'(exp_hits));
        checkOutput("miss_count_final", miss_count, 32'(exp_misses));
`endif
        finish_test();
    end

endmodule
